// File: rtl/lfsr_rand_coord.sv
// lfsr_rand_coord: pseudo-random coordinate generator.
//
// A WIDTH-bit Fibonacci LFSR (feedback mask TAPS) is stepped on request until
// its next state lies in [0, LIMIT). That value is returned via out/out_valid
// and held until the consumer takes it with out_ready.
//
// Optional feature: define LFSR_SEED_LOAD_EN to honour seed_ld/seed_in in IDLE.
// Without it the ports remain, but seed_ld is ignored and only clr seeds the LFSR.
//
// Ports:
//   clk        system clock, rising edge
//   clr        synchronous active-high reset, overrides every other input
//   en         stir enable: step the LFSR every cycle while IDLE
//   seed_ld    load seed_in into the LFSR (IDLE only, optional feature)
//   seed_in    seed value; 0 loads 1 so the LFSR cannot lock up
//   req        request a new coordinate
//   out_ready  consumer accepts out
//   out        emitted coordinate
//   out_valid  out holds an unconsumed value
//   busy       registered, high while in SEARCH or HOLD

module lfsr_rand_coord #(
    parameter int unsigned      WIDTH = 10,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(10'h009),
    parameter int unsigned      LIMIT = 640,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             seed_ld,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy
);

    // One extra bit so that LIMIT = 2^WIDTH is representable and accepts everything.
    localparam logic [WIDTH:0] LimitW = (WIDTH + 1)'(LIMIT);

    typedef enum logic [1:0] {StIdle, StSearch, StHold} fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q;

    logic [WIDTH-1:0] lfsr_step;
    logic             step_ok;
    logic             seed_take;
    logic [WIDTH-1:0] seed_value;
    logic             xfer;

    assign lfsr_step = {^(lfsr_q & TAPS), lfsr_q[WIDTH-1:1]};
    assign step_ok   = {1'b0, lfsr_step} < LimitW;
    assign xfer      = out_valid_q && out_ready;

`ifdef LFSR_SEED_LOAD_EN
    assign seed_take  = seed_ld;
    assign seed_value = (seed_in == '0) ? WIDTH'(1) : seed_in;
`else
    logic unused_seed;
    assign seed_take   = 1'b0;
    assign seed_value  = SEED;
    assign unused_seed = ^{seed_ld, seed_in};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            fsm_q       <= StIdle;
            lfsr_q      <= SEED;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            lfsr_q      <= lfsr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= (fsm_d != StIdle);
        end
    end

    // Next-state logic.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            StIdle: begin
                if (!seed_take && req) begin
                    fsm_d = step_ok ? StHold : StSearch;
                end
            end
            StSearch: begin
                if (step_ok) begin
                    fsm_d = StHold;
                end
            end
            StHold: begin
                if (xfer) begin
                    fsm_d = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    // Datapath / output next values.
    always_comb begin
        lfsr_d      = lfsr_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (fsm_q)
            StIdle: begin
                if (seed_take) begin
                    lfsr_d = seed_value;
                end else if (req) begin
                    lfsr_d = lfsr_step;
                    if (step_ok) begin
                        out_d       = lfsr_step;
                        out_valid_d = 1'b1;
                    end
                end else if (en) begin
                    lfsr_d = lfsr_step;
                end
            end
            StSearch: begin
                lfsr_d = lfsr_step;
                if (step_ok) begin
                    out_d       = lfsr_step;
                    out_valid_d = 1'b1;
                end
            end
            StHold: begin
                // LFSR frozen; only the handshake can release the value.
                if (xfer) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lfsr_rand_coord.sv
module tb_lfsr_rand_coord;

    logic       clk = 1'b0;
    logic       clr = 1'b0, en = 1'b0, seed_ld = 1'b0, req = 1'b0, out_ready = 1'b0;
    logic [9:0] seed_in = '0;
    logic [9:0] out;
    logic       out_valid, busy;

    // Second instance for the LIMIT=480 sweep.
    logic       s_clr = 1'b1, s_req = 1'b0, s_ready = 1'b0;
    logic       s_zero = 1'b0;
    logic [9:0] s_seed = '0;
    logic [9:0] s_out;
    logic       s_valid, s_busy;

    int n_pass = 0;
    int n_total = 0;
    int drop_errs = 0;

    always #5 clk = ~clk;

    lfsr_rand_coord #(.WIDTH(10), .TAPS(10'h009), .LIMIT(640), .SEED(10'd1)) u_dut (
        .clk(clk), .clr(clr), .en(en), .seed_ld(seed_ld), .seed_in(seed_in), .req(req),
        .out_ready(out_ready), .out(out), .out_valid(out_valid), .busy(busy)
    );

    lfsr_rand_coord #(.WIDTH(10), .TAPS(10'h009), .LIMIT(480), .SEED(10'd1)) u_sweep (
        .clk(clk), .clr(s_clr), .en(s_zero), .seed_ld(s_zero), .seed_in(s_seed),
        .req(s_req), .out_ready(s_ready), .out(s_out), .out_valid(s_valid), .busy(s_busy)
    );

    typedef struct {
        logic       clr, en, req, rdy;
        logic [9:0] exp_out;
        logic       exp_valid, exp_busy;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic c, input logic e, input logic r, input logic y,
                                input int eo, input logic ev, input logic eb);
        vec_t v;
        v.clr = c; v.en = e; v.req = r; v.rdy = y;
        v.exp_out = 10'(eo); v.exp_valid = ev; v.exp_busy = eb;
        return v;
    endfunction

    // Reference step for taps {0,3}: feedback enters at the MSB.
    function automatic logic [9:0] mstep(input logic [9:0] s);
        return {s[0] ^ s[3], s[9:1]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    // From a freshly cleared DUT (state 1), bring the LFSR to 0x301.
    task automatic goto_301();
`ifdef LFSR_SEED_LOAD_EN
        seed_ld = 1'b1; seed_in = 10'h301; tick(); seed_ld = 1'b0;
`else
        logic [9:0] s;
        int n;
        s = 10'd1; n = 0;
        while (s != 10'h301 && n < 1023) begin s = mstep(s); n++; end
        chk("reach_0x301", int'(s), 'h301);
        en = 1'b1;
        repeat (n) tick();
        en = 1'b0;
`endif
    endtask

    // out_valid must not drop, nor out change, unless a transfer happened.
    logic       mon_v, mon_r;
    logic [9:0] mon_out;
    always begin
        @(posedge clk);
        mon_v = s_valid; mon_r = s_ready; mon_out = s_out;
        #1;
        if (!s_clr && mon_v && !mon_r && (!s_valid || s_out != mon_out)) drop_errs++;
    end

    logic [9:0] hist[2000];

    initial begin
        //              clr en req rdy  out  v  b
        vecs[0]  = mk(1, 0, 0, 0,   0, 0, 0);
        vecs[1]  = mk(0, 0, 1, 0, 512, 1, 1);
        vecs[2]  = mk(0, 0, 0, 1, 512, 0, 0);
        vecs[3]  = mk(0, 0, 1, 0, 256, 1, 1);
        vecs[4]  = mk(0, 0, 0, 0, 256, 1, 1);
        vecs[5]  = mk(0, 0, 0, 1, 256, 0, 0);
        vecs[6]  = mk(0, 0, 1, 1, 128, 1, 1);   // ready ignored while not valid
        vecs[7]  = mk(0, 0, 0, 1, 128, 0, 0);
        vecs[8]  = mk(0, 1, 0, 0, 128, 0, 0);   // stir: 0x080 -> 0x040
        vecs[9]  = mk(0, 0, 1, 0,  32, 1, 1);
        vecs[10] = mk(0, 1, 1, 0,  32, 1, 1);   // en/req ignored in HOLD
        vecs[11] = mk(0, 0, 0, 1,  32, 0, 0);
        vecs[12] = mk(0, 0, 1, 0,  16, 1, 1);
        vecs[13] = mk(0, 0, 0, 1,  16, 0, 0);
        vecs[14] = mk(0, 0, 1, 0,   8, 1, 1);
        vecs[15] = mk(0, 0, 0, 1,   8, 0, 0);
        vecs[16] = mk(0, 0, 1, 0, 516, 1, 1);
        vecs[17] = mk(1, 0, 0, 0,   0, 0, 0);   // clr in HOLD
        vecs[18] = mk(0, 0, 1, 0, 512, 1, 1);
        vecs[19] = mk(1, 0, 1, 1,   0, 0, 0);   // clr beats req/ready
        vecs[20] = mk(0, 0, 1, 0, 512, 1, 1);
        vecs[21] = mk(0, 0, 0, 1, 512, 0, 0);

        tick();
        for (int i = 0; i < 22; i++) begin
            clr = vecs[i].clr; en = vecs[i].en; req = vecs[i].req; out_ready = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d_out", i), int'(out), int'(vecs[i].exp_out));
            chk($sformatf("vec%0d_valid", i), int'(out_valid), int'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
        end
        clr = 0; en = 0; req = 0; out_ready = 0;

        // Rejection: 0x301 -> 896 rejected -> 448 accepted one cycle later.
        do_clr();
        goto_301();
        req = 1'b1; tick(); req = 1'b0;
        chk("rej_search_valid", int'(out_valid), 0);
        chk("rej_search_busy", int'(busy), 1);
        tick();
        chk("rej_valid", int'(out_valid), 1);
        chk("rej_out", int'(out), 448);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("rej_xfer_valid", int'(out_valid), 0);

        // Mid-SEARCH reset returns to SEED.
        do_clr();
        goto_301();
        req = 1'b1; tick(); req = 1'b0;
        chk("midclr_in_search", int'(busy), 1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("midclr_valid", int'(out_valid), 0);
        chk("midclr_busy", int'(busy), 0);
        chk("midclr_out", int'(out), 0);
        req = 1'b1; tick(); req = 1'b0;
        chk("midclr_req_out", int'(out), 512);
        chk("midclr_req_valid", int'(out_valid), 1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Zero guard (or ignored seed load) followed by a stalled HOLD.
        do_clr();
`ifdef LFSR_SEED_LOAD_EN
        seed_in = 10'h000;
`else
        seed_in = 10'h301;
`endif
        seed_ld = 1'b1; tick(); seed_ld = 1'b0;
        req = 1'b1; tick(); req = 1'b0;
        chk("stall_first_out", int'(out), 512);
        seed_in = 10'h301;
        for (int i = 0; i < 5; i++) begin
            en = i[0]; req = ~i[0]; seed_ld = i[1];
            tick();
            chk($sformatf("stall%0d_out", i), int'(out), 512);
            chk($sformatf("stall%0d_valid", i), int'(out_valid), 1);
        end
        en = 0; req = 0; seed_ld = 0;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("stall_xfer_valid", int'(out_valid), 0);
        req = 1'b1; tick(); req = 1'b0;
        chk("stall_frozen_next", int'(out), 256);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Range sweep, LIMIT=480, random consumer back-pressure.
        begin
            logic [9:0] ms;
            int n, reps;
            logic took;
            s_clr = 1'b1; tick(); s_clr = 1'b0;
            ms = 10'd1;
            for (int k = 0; k < 2000; k++) begin
                s_req = 1'b1; s_ready = 1'($urandom_range(0, 1)); tick(); s_req = 1'b0;
                n = 0;
                while (!s_valid && n < 1100) begin
                    s_ready = 1'($urandom_range(0, 1)); tick(); n++;
                end
                if (!s_valid) begin
                    chk("sweep_timeout", 0, 1);
                    break;
                end
                do ms = mstep(ms); while (ms >= 10'd480);
                n_total++;
                if (s_out == ms && s_out < 10'd480) n_pass++;
                else $display("FAIL sweep%0d_value: got %0d, expected %0d", k, s_out, ms);
                // The in-range orbit has 479 values (1..479), so repeats only at distance 479.
                hist[k] = s_out;
                reps = 0;
                for (int j = (k > 478 ? k - 478 : 0); j < k; j++)
                    if (hist[j] == s_out) reps++;
                chk($sformatf("sweep%0d_window", k), reps, 0);
                n = 0;
                do begin
                    s_ready = 1'($urandom_range(0, 1)); took = s_ready; tick(); n++;
                end while (!took && n < 100);
                if (!took) begin s_ready = 1'b1; tick(); end
                s_ready = 1'b0;
                if (s_valid || s_busy) begin
                    chk("sweep_release", int'({s_valid, s_busy}), 0);
                    break;
                end
            end
            chk("sweep_no_drop", drop_errs, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
